// File: rtl/cnt_pkg.sv
// Shared types and helpers for the counters library.
package cnt_pkg;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  // Widths are fixed at 33 bits so any WIDTH up to 32 fits, including MOD == 2**WIDTH.
  function automatic logic [32:0] clamp_mod(input logic [32:0] val, input logic [32:0] mod);
    return (val >= mod) ? (mod - 33'd1) : val;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_modcounter.sv
// Modulo-MOD up/down counter with load, one-shot mode and status flags, stored in JK cells.
module jk_modcounter
  import cnt_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MOD     = 10,
  parameter int     ONESHOT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "jk_modcounter: WIDTH must be 1..32");
  end
  if (MOD < 2 || MOD > (longint'(1) << WIDTH)) begin : g_bad_mod
    $fatal(1, "jk_modcounter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end
  if (ONESHOT != 0 && ONESHOT != 1) begin : g_bad_oneshot
    $fatal(1, "jk_modcounter: ONESHOT must be 0 or 1");
  end

  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] nxt;
  jk_t  [WIDTH-1:0] jk;
  logic             wrap_n;
  logic             done_n;
  logic             err_n;

  assign tc = up ? (q_r == MAXV) : (q_r == '0);
  assign q  = q_r;

  // A terminal count is exactly the point where an enabled step would wrap.
  always_comb begin
    nxt    = q_r;
    wrap_n = 1'b0;
    done_n = done;
    err_n  = 1'b0;
    if (load) begin
      nxt    = WIDTH'(clamp_mod(33'(load_val), 33'(MOD_W)));
      err_n  = ({1'b0, load_val} >= MOD_W);
      done_n = 1'b0;
    end else if (en && !done) begin
      if (oneshot && tc) begin
        done_n = 1'b1;
      end else if (up) begin
        nxt    = (q_r == MAXV) ? '0 : q_r + WIDTH'(1);
        wrap_n = (q_r == MAXV);
      end else begin
        nxt    = (q_r == '0) ? MAXV : q_r - WIDTH'(1);
        wrap_n = (q_r == '0);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      jk[i].j = ~q_r[i] &  nxt[i];
      jk[i].k =  q_r[i] & ~nxt[i];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk[i].j),
      .k   (jk[i].k),
      .q   (q_r[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_n;
      done     <= done_n;
      load_err <= err_n;
    end
  end

endmodule

// File: tb/tb_jk_modcounter.sv
// Directed-vector bench for jk_modcounter (MOD=10 table plus a WIDTH=3/MOD=8 wrap sequence).
module tb_jk_modcounter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, oneshot;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap, done, load_err;

  logic       c_rst, c_en, c_up, c_load, c_oneshot;
  logic [2:0] c_load_val;
  logic [2:0] c_q;
  logic       c_tc, c_wrap, c_done, c_load_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst, load, en, up, oneshot;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap, done, err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  jk_modcounter #(.WIDTH(4), .MOD(10), .ONESHOT(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .oneshot(oneshot), .q(q), .tc(tc), .wrap(wrap), .done(done), .load_err(load_err)
  );

  jk_modcounter #(.WIDTH(3), .MOD(8), .ONESHOT(0)) dut8 (
    .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load), .load_val(c_load_val),
    .oneshot(c_oneshot), .q(c_q), .tc(c_tc), .wrap(c_wrap), .done(c_done), .load_err(c_load_err)
  );

  task automatic addVec(input string name, input logic r, input logic ld, input logic [3:0] lv,
                        input logic e, input logic u, input logic os, input logic [3:0] eq,
                        input logic etc, input logic ew, input logic ed, input logic ee);
    vec_t v;
    v.name = name; v.rst = r; v.load = ld; v.load_val = lv; v.en = e; v.up = u; v.oneshot = os;
    v.q = eq; v.tc = etc; v.wrap = ew; v.done = ed; v.err = ee;
    vecs.push_back(v);
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue($sformatf("%s[%0d].q", v.name, idx),    32'(q),        32'(v.q));
    checkValue($sformatf("%s[%0d].tc", v.name, idx),   32'(tc),       32'(v.tc));
    checkValue($sformatf("%s[%0d].wrap", v.name, idx), 32'(wrap),     32'(v.wrap));
    checkValue($sformatf("%s[%0d].done", v.name, idx), 32'(done),     32'(v.done));
    checkValue($sformatf("%s[%0d].err", v.name, idx),  32'(load_err), 32'(v.err));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; load = v.load; load_val = v.load_val;
    en = v.en; up = v.up; oneshot = v.oneshot;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1; oneshot = 1'b0;
    c_rst = 1'b1; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_load_val = '0; c_oneshot = 1'b0;

    //      name     rst ld lv  en up os  q tc wr dn er
    addVec("reset",  1, 0, 0,  0, 1, 0,  0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      addVec("up",   0, 0, 0,  1, 1, 0,  4'(i % 10), (i == 9), (i == 10), 0, 0);
    addVec("ld3",    0, 1, 3,  0, 0, 0,  3, 0, 0, 0, 0);
    addVec("down",   0, 0, 0,  1, 0, 0,  2, 0, 0, 0, 0);
    addVec("down",   0, 0, 0,  1, 0, 0,  1, 0, 0, 0, 0);
    addVec("down",   0, 0, 0,  1, 0, 0,  0, 1, 0, 0, 0);
    addVec("down",   0, 0, 0,  1, 0, 0,  9, 0, 1, 0, 0);
    addVec("down",   0, 0, 0,  1, 0, 0,  8, 0, 0, 0, 0);
    addVec("ld12",   0, 1, 12, 0, 0, 0,  9, 0, 0, 0, 1);
    addVec("hold",   0, 0, 0,  0, 0, 0,  9, 0, 0, 0, 0);
    addVec("ld7",    0, 1, 7,  0, 0, 0,  7, 0, 0, 0, 0);
    addVec("os_ld7", 0, 1, 7,  0, 1, 1,  7, 0, 0, 0, 0);
    addVec("os_up",  0, 0, 0,  1, 1, 1,  8, 0, 0, 0, 0);
    addVec("os_up",  0, 0, 0,  1, 1, 1,  9, 1, 0, 0, 0);
    addVec("os_up",  0, 0, 0,  1, 1, 1,  9, 1, 0, 1, 0);
    addVec("os_up",  0, 0, 0,  1, 1, 1,  9, 1, 0, 1, 0);
    addVec("os_off", 0, 0, 0,  1, 1, 0,  9, 1, 0, 1, 0);
    addVec("os_ld0", 0, 1, 0,  0, 1, 0,  0, 0, 0, 0, 0);
    addVec("resume", 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0);
    addVec("os_ld2", 0, 1, 2,  0, 0, 1,  2, 0, 0, 0, 0);
    addVec("os_dn",  0, 0, 0,  1, 0, 1,  1, 0, 0, 0, 0);
    addVec("os_dn",  0, 0, 0,  1, 0, 1,  0, 1, 0, 0, 0);
    addVec("os_dn",  0, 0, 0,  1, 0, 1,  0, 1, 0, 1, 0);
    addVec("ld5",    0, 1, 5,  0, 1, 0,  5, 0, 0, 0, 0);
    addVec("to6",    0, 0, 0,  1, 1, 0,  6, 0, 0, 0, 0);
    addVec("rstpri", 1, 1, 5,  1, 1, 0,  0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // tc must track up without waiting for a clock edge (q is 0 here, no enable).
    en = 1'b0; load = 1'b0; rst = 1'b0;
    up = 1'b1; #1;
    checkValue("tc_comb_up", 32'(tc), 32'(0));
    up = 1'b0; #1;
    checkValue("tc_comb_down", 32'(tc), 32'(1));

    // WIDTH=3, MOD=8: natural binary wrap in both directions.
    @(negedge clk);
    c_rst = 1'b1;
    @(posedge clk); #1;
    checkValue("m8_reset_q", 32'(c_q), 32'(0));
    @(negedge clk);
    c_rst = 1'b0; c_en = 1'b1; c_up = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checkValue($sformatf("m8_up%0d_q", k), 32'(c_q), 32'(k % 8));
      checkValue($sformatf("m8_up%0d_wrap", k), 32'(c_wrap), 32'(k == 8));
    end
    @(negedge clk);
    c_up = 1'b0;
    @(posedge clk); #1;
    checkValue("m8_down_q", 32'(c_q), 32'(7));
    checkValue("m8_down_wrap", 32'(c_wrap), 32'(1));
    @(negedge clk);
    c_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
